pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 2, number of carry-slice pipeline stages; legal 1..WIDTH, WIDTH divisible by STAGES (slice = WIDTH/STAGES bits).
REQ-003 SHALL have parameter TAG_WIDTH, default 6, width of the opaque passthrough tag (ROB index).
REQ-004 SHALL have one clock and an asynchronous active-low reset, as follows: clk  in  1  rising-edge clock.
REQ-005 rst_aL  in  1  asynchronous reset, active-low.
REQ-006 in_valid  in  1  operand transaction offered.
REQ-007 in_ready  out  1  block accepts transaction this cycle.
REQ-008 in_a  in  WIDTH  operand A.
REQ-009 in_b  in  WIDTH  operand B.
REQ-010 in_sub  in  1  1 = A - B, 0 = A + B.
REQ-011 in_tag  in  TAG_WIDTH  passthrough tag.
REQ-012 flush  in  1  synchronous kill of all in-flight transactions.
REQ-013 out_valid  out  1  result available.
REQ-014 out_ready  in  1  consumer takes result this cycle.
REQ-015 out_sum  out  WIDTH  result, modulo 2^WIDTH.
REQ-016 out_cout  out  1  carry-out of MSB (for sub: 1 = no borrow).
REQ-017 out_ovf  out  1  two's-complement signed overflow.
REQ-018 out_tag  out  TAG_WIDTH  tag of the result transaction.

Function
REQ-019 Transfer on input when in_valid && in_ready at a rising edge; on output when out_valid && out_ready.
REQ-020 Subtract SHALL be computed as A + ~B + 1 (B inverted, carry-in 1); add uses carry-in 0.
REQ-021 Stage k (0..STAGES-1) SHALL add slice k of A and B' with the carry registered from stage k-1 (stage 0 uses the mode carry-in); each stage register holds valid, completed low slices, pending high operand slices, slice carry, sub-free operands and tag.
REQ-022 Only one slice-width carry chain per stage; no full-width carry path between registers.
REQ-023 Latency: transaction accepted at edge t SHALL present out_valid and results after edge t+STAGES-1 when no stall occurs (STAGES=1: after edge t).
REQ-024 Throughput: one transaction per cycle sustained when out_ready stays high.
REQ-025 Elastic: a stage SHALL load when it is empty or its content advances the same edge; bubbles SHALL collapse under downstream stall.
REQ-026 in_ready SHALL be 1 iff stage 0 is empty or stage 0 advances this edge; may depend combinationally on out_ready.
REQ-027 While out_valid && !out_ready, out_sum/out_cout/out_ovf/out_tag SHALL hold stable; no transaction lost or duplicated.
REQ-028 Results SHALL leave in acceptance order.
REQ-029 out_ovf SHALL equal (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), B' the effective (possibly inverted) B.
REQ-030 flush SHALL clear every stage valid bit at the next edge; a transaction offered in the flush cycle SHALL be dropped; in_ready SHALL be 0 during flush; out_valid SHALL be 0 the cycle after flush.
REQ-031 flush coincident with an output handshake: that output transfer SHALL still count as completed.
REQ-032 Data registers need no reset; only valid bits are reset.

Reset
REQ-033 On rst_aL low, all stage valid bits SHALL clear immediately (asynchronous); out_valid = 0 while reset asserted; in_ready = 0 while reset asserted.
REQ-034 Reset mid-operation SHALL discard all in-flight transactions; after release, first accepted transaction obeys REQ-023.
REQ-035 Reset release SHALL take effect at the first rising edge after rst_aL goes high.

Verification (WIDTH=32, STAGES=4, TAG_WIDTH=6)
REQ-036 Add 0xFFFFFFFF + 0x00000001, tag 5, out_ready=1 -> 3 edges later out_sum=0x00000000, out_cout=1, out_ovf=0, out_tag=5.
REQ-037 Sub 0x80000000 - 0x00000001 -> out_sum=0x7FFFFFFF, out_cout=1, out_ovf=1; add 0x7FFFFFFF + 1 -> 0x80000000, ovf=1, cout=0.
REQ-038 Stream 8 back-to-back adds (i + i, tags 0..7), out_ready=1 -> 8 consecutive out_valid cycles, sums 0,2,..,14, tags in order.
REQ-039 Stream 6 transactions with out_ready=0 -> in_ready drops after 4 accepted; outputs stable; raising out_ready drains all 6 in order.
REQ-040 Flush with 3 in flight and a new offer same cycle -> next cycle out_valid=0, none of the 4 ever appears.
REQ-041 Assert rst_aL=0 asynchronously mid-stream -> out_valid=0 before the next edge; post-release transaction A=3,B=4 yields 7 with correct latency.

Source files
------------

// File: rtl/pipelined_adder_if.sv
// Handshake bundle for the pipelined adder: operand request channel and result channel.
// The slave modport is the adder's view of the bundle; the master modport is the producer/consumer view.
interface pipelined_adder_if #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 6
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_sub;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_sum;
  logic                 out_cout;
  logic                 out_ovf;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );
endinterface

// File: rtl/pipelined_adder.sv
// Elastic add/subtract pipeline: each stage resolves one WIDTH/STAGES-bit slice with the carry
// registered by the stage before it, carrying pending high operand slices and the tag along.
module pipelined_adder #(
  parameter int WIDTH     = 32,
  parameter int STAGES    = 2,
  parameter int TAG_WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic             flush,
  pipelined_adder_if.slave ifc
);
  localparam int SLICE = WIDTH / STAGES;

  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_ready;

  // A stage may load when it is empty or its occupant moves on this edge.
  always_comb begin
    w_ready = {STAGES{1'b0}};
    w_ready[STAGES-1] = !w_valid[STAGES-1] || ifc.out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_ready[k] = !w_valid[k] || w_ready[k+1];
    end
  end

  assign ifc.in_ready = rst_aL && !flush && w_ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int PEND = WIDTH - k * SLICE;

    logic [PEND-1:0]          w_a_src;
    logic [PEND-1:0]          w_b_src;
    logic                     w_cy_src;
    logic                     w_v_src;
    logic [TAG_WIDTH-1:0]     w_tag_src;
    logic [SLICE:0]           w_slice;
    logic [(k+1)*SLICE-1:0]   w_sum_new;

    logic                     r_valid;
    logic                     r_cy;
    logic [(k+1)*SLICE-1:0]   r_sum;
    logic [TAG_WIDTH-1:0]     r_tag;

    // Stage 0 inverts B for subtract and seeds the carry with the mode bit.
    if (k == 0) begin : g_src
      assign w_a_src   = ifc.in_a;
      assign w_b_src   = ifc.in_sub ? ~ifc.in_b : ifc.in_b;
      assign w_cy_src  = ifc.in_sub;
      assign w_v_src   = ifc.in_valid;
      assign w_tag_src = ifc.in_tag;
      assign w_sum_new = w_slice[SLICE-1:0];
    end else begin : g_src
      assign w_a_src   = g_stage[k-1].g_ops.r_a;
      assign w_b_src   = g_stage[k-1].g_ops.r_b;
      assign w_cy_src  = g_stage[k-1].r_cy;
      assign w_v_src   = g_stage[k-1].r_valid;
      assign w_tag_src = g_stage[k-1].r_tag;
      assign w_sum_new = {w_slice[SLICE-1:0], g_stage[k-1].r_sum};
    end

    assign w_slice = {1'b0, w_a_src[SLICE-1:0]} + {1'b0, w_b_src[SLICE-1:0]}
                   + {{SLICE{1'b0}}, w_cy_src};
    assign w_valid[k] = r_valid;

    // Stage occupancy: cleared by reset or flush, otherwise follows upstream when loadable.
    always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
        r_valid <= 1'b0;
      end else if (flush) begin
        r_valid <= 1'b0;
      end else if (w_ready[k]) begin
        r_valid <= w_v_src;
      end else begin
        r_valid <= r_valid;
      end
    end

    // Payload registers carry no reset; they are qualified by r_valid.
    always_ff @(posedge clk) begin
      if (w_ready[k] && w_v_src) begin
        r_sum <= w_sum_new;
        r_cy  <= w_slice[SLICE];
        r_tag <= w_tag_src;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [PEND-SLICE-1:0] r_a;
      logic [PEND-SLICE-1:0] r_b;

      // Only the operand slices not yet summed travel onward.
      always_ff @(posedge clk) begin
        if (w_ready[k] && w_v_src) begin
          r_a <= w_a_src[PEND-1:SLICE];
          r_b <= w_b_src[PEND-1:SLICE];
        end
      end
    end else begin : g_last
      logic r_ovf;

      // Signed overflow uses the effective (possibly inverted) B sign bit.
      always_ff @(posedge clk) begin
        if (w_ready[k] && w_v_src) begin
          r_ovf <= (w_a_src[PEND-1] == w_b_src[PEND-1]) && (w_slice[SLICE-1] != w_a_src[PEND-1]);
        end
      end
    end
  end

  assign ifc.out_valid = g_stage[STAGES-1].r_valid;
  assign ifc.out_sum   = g_stage[STAGES-1].r_sum;
  assign ifc.out_cout  = g_stage[STAGES-1].r_cy;
  assign ifc.out_ovf   = g_stage[STAGES-1].g_last.r_ovf;
  assign ifc.out_tag   = g_stage[STAGES-1].r_tag;
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder at WIDTH=32, STAGES=4, TAG_WIDTH=6.
module tb_pipelined_adder;
  localparam int WIDTH     = 32;
  localparam int STAGES    = 4;
  localparam int TAG_WIDTH = 6;

  logic clk    = 1'b0;
  logic rst_aL = 1'b0;
  logic flush  = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  pipelined_adder_if #(.WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH)) ifc ();

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_WIDTH(TAG_WIDTH)) dut (
    .clk    (clk),
    .rst_aL (rst_aL),
    .flush  (flush),
    .ifc    (ifc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [5:0] tag);
    ifc.in_a     = a;
    ifc.in_b     = b;
    ifc.in_sub   = sub;
    ifc.in_tag   = tag;
    ifc.in_valid = 1'b1;
  endtask

  // Stall-test vector k: a=100+k, b=3k, subtract on odd k.
  task automatic put(input int k);
    drive(32'd100 + 32'(k), 32'(3 * k), (k % 2) == 1, 6'd10 + 6'(k));
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [5:0] tag);
    drive(a, b, sub, tag);
    @(negedge clk);
    check("issue_ready", 64'(ifc.in_ready), 64'd1);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic expect_result(input string nm, input logic [31:0] sum, input logic cout,
                               input logic ovf, input logic [5:0] tag);
    int n;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ifc.out_valid) break;
      @(posedge clk);
    end
    check({nm, "_lat"},  64'(n), 64'd3);
    check({nm, "_sum"},  64'(ifc.out_sum), 64'(sum));
    check({nm, "_cout"}, 64'(ifc.out_cout), 64'(cout));
    check({nm, "_ovf"},  64'(ifc.out_ovf), 64'(ovf));
    check({nm, "_tag"},  64'(ifc.out_tag), 64'(tag));
    @(posedge clk);
    #1;
  endtask

  logic [31:0] e_sum [6] = '{32'd100, 32'd98, 32'd108, 32'd94, 32'd116, 32'd90};

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_a      = 32'd0;
    ifc.in_b      = 32'd0;
    ifc.in_sub    = 1'b0;
    ifc.in_tag    = 6'd0;
    ifc.out_ready = 1'b1;

    #12;
    check("rst_ov", 64'(ifc.out_valid), 64'd0);
    check("rst_ir", 64'(ifc.in_ready), 64'd0);
    #5 rst_aL = 1'b1;
    @(posedge clk);
    #1;

    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 6'd5);
    expect_result("wrap", 32'h0000_0000, 1'b1, 1'b0, 6'd5);
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, 6'd6);
    expect_result("subovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 6'd6);
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 6'd7);
    expect_result("addovf", 32'h8000_0000, 1'b0, 1'b1, 6'd7);
    issue(32'd5, 32'd7, 1'b1, 6'd8);
    expect_result("borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 6'd8);

    // Eight back-to-back adds with an always-ready consumer.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          drive(32'(i), 32'(i), 1'b0, 6'(i));
          @(negedge clk);
          check("s8_ready", 64'(ifc.in_ready), 64'd1);
          @(posedge clk);
          #1;
        end
        ifc.in_valid = 1'b0;
      end
      begin
        int n;
        for (n = 0; n < 20; n++) begin
          @(negedge clk);
          if (ifc.out_valid) break;
        end
        check("s8_lat", 64'(n), 64'd4);
        for (int j = 0; j < 8; j++) begin
          if (j > 0) @(negedge clk);
          check("s8_ov",  64'(ifc.out_valid), 64'd1);
          check("s8_sum", 64'(ifc.out_sum), 64'(2 * j));
          check("s8_tag", 64'(ifc.out_tag), 64'(j));
        end
      end
    join
    @(posedge clk);
    #1;

    // Consumer stalled: four fill the pipe, then the fifth offer is refused.
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(i);
      @(negedge clk);
      check("stall_acc", 64'(ifc.in_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    put(4);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      check("stall_full", 64'(ifc.in_ready), 64'd0);
      check("stall_ov",   64'(ifc.out_valid), 64'd1);
      check("stall_sum",  64'(ifc.out_sum), 64'd100);
      check("stall_tag",  64'(ifc.out_tag), 64'd10);
      @(posedge clk);
      #1;
    end
    ifc.out_ready = 1'b1;
    fork
      begin
        for (int k = 4; k < 6; k++) begin
          logic acc;
          acc = 1'b0;
          put(k);
          for (int w = 0; w < 10 && !acc; w++) begin
            @(negedge clk);
            acc = ifc.in_ready;
            @(posedge clk);
            #1;
          end
          check("drain_acc", 64'(acc), 64'd1);
        end
        ifc.in_valid = 1'b0;
      end
      begin
        int idx;
        idx = 0;
        for (int c = 0; c < 40 && idx < 6; c++) begin
          @(negedge clk);
          if (ifc.out_valid) begin
            check("drain_sum", 64'(ifc.out_sum), 64'(e_sum[idx]));
            check("drain_tag", 64'(ifc.out_tag), 64'(10 + idx));
            idx++;
          end
        end
        check("drain_cnt", 64'(idx), 64'd6);
      end
    join
    @(posedge clk);
    #1;

    // Flush with three in flight plus a same-cycle offer.
    for (int i = 0; i < 3; i++) begin
      drive(32'(i), 32'h10, 1'b0, 6'd30 + 6'(i));
      @(posedge clk);
      #1;
    end
    drive(32'd1, 32'd1, 1'b0, 6'd40);
    flush = 1'b1;
    @(negedge clk);
    check("flush_ir", 64'(ifc.in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush        = 1'b0;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    check("flush_ov", 64'(ifc.out_valid), 64'd0);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (ifc.out_valid) seen++;
      end
      check("flush_none", 64'(seen), 64'd0);
    end
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 4; i++) begin
      drive(32'(i), 32'd1, 1'b0, 6'd50 + 6'(i));
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
    @(negedge clk);
    check("mid_pre_ov", 64'(ifc.out_valid), 64'd1);
    #2 rst_aL = 1'b0;
    #1;
    check("mid_rst_ov", 64'(ifc.out_valid), 64'd0);
    check("mid_rst_ir", 64'(ifc.in_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_aL = 1'b1;
    @(posedge clk);
    #1;
    issue(32'd3, 32'd4, 1'b0, 6'd9);
    expect_result("post_rst", 32'd7, 1'b0, 1'b0, 6'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
